led_event_encoder: RTL and testbench
====================================

LED_EVENT_ENCODER -- requirements
Module: led_event_encoder

Interface
REQ-001 Parameter DEB_CYCLES, default 3125, is the number of consecutive stable cycles that debounce fault_sense and node_sense (1 ms at 3.125 MHz).
REQ-002 Parameter HOLD_CYCLES, default 3125000, is the number of cycles object_drop stays asserted after a drop (1 s).
REQ-003 clk_3125KHz  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 unit_sel  input  2  current zone from the path planner: 00 none, 01 EU, 10 CU, 11 RU.
REQ-006 fault_sense  input  1  raw fault-detection sensor level; asynchronous, bouncy.
REQ-007 node_sense  input  1  raw line-sensor node level; asynchronous, bouncy.
REQ-008 pick_done  input  1  one-cycle pulse from the arm controller when a block is gripped.
REQ-009 drop_done  input  1  one-cycle pulse from the arm controller when a block is released.
REQ-010 run_done  input  1  one-cycle pulse from the planner when the run ends.
REQ-011 fault_detect  output  1  level; debounced fault seen in the active zone.
REQ-012 block_picked  output  1  level; a block is held.
REQ-013 node_flag  output  1  one-cycle pulse on a debounced node_sense rising edge.
REQ-014 object_drop  output  1  asserted for HOLD_CYCLES after a drop.
REQ-015 run_complete  output  1  sticky completion level.
REQ-016 EU_fault_flag, CU_fault_flag, RU_fault_flag  output  1 each  one-hot zone-active flags.

Function
REQ-017 fault_sense and node_sense SHALL each pass through a 2-flop synchroniser before any other use.
REQ-018 Each debounced level SHALL change only after the synchronised input differs from it for DEB_CYCLES consecutive cycles; any agreement cycle resets that input's counter to 0.
REQ-019 The FSM SHALL have the states IDLE, ARMED, FAULT, HOLDING, DROPPED and DONE.
REQ-020 IDLE: all outputs 0; a non-zero unit_sel latches the zone and moves to ARMED.
REQ-021 ARMED: the latched zone flag is 1; a debounced fault moves to FAULT.
REQ-022 FAULT: fault_detect is 1 and the zone flag is 1; pick_done moves to HOLDING.
REQ-023 HOLDING: block_picked is 1, fault_detect is 0 and the zone flag is 1; drop_done moves to DROPPED and loads the hold counter with HOLD_CYCLES-1.
REQ-024 DROPPED: object_drop is 1 and the zone flag is 1; the counter decrements each cycle, and on reaching 0 the FSM returns to IDLE and clears the zone latch.
REQ-025 run_done in any state SHALL move to DONE on the next edge; DONE sets run_complete=1, clears all other outputs, and is exited only by reset.
REQ-026 Simultaneous events: run_done has highest priority; within a state only the listed transition is honoured, and other pulses are ignored, not queued.
REQ-027 A unit_sel change outside IDLE SHALL be ignored; the latched zone holds until the return to IDLE.
REQ-028 node_flag SHALL be generated in every state except DONE and is independent of the FSM.
REQ-029 All outputs SHALL be registered, with latency of 1 cycle from the qualifying event to the output change.
REQ-030 Counters SHALL be sized by $clog2 of their parameter and SHALL NOT wrap: the debounce counter saturates at DEB_CYCLES and the hold counter stops at 0.

Reset
REQ-031 rst_n low SHALL immediately force the FSM to IDLE, all outputs to 0, all counters to 0, the synchronisers and debounced levels to 0, and the zone latch to 00.
REQ-032 Reset asserted mid-hold or while in DONE SHALL abandon the operation with no residual pulse after release.

Verification (DEB_CYCLES=4, HOLD_CYCLES=10)
REQ-033 Full sequence: unit_sel=10 -> CU_fault_flag=1; fault_sense high for 6 cycles -> fault_detect=1; pick_done -> block_picked=1; drop_done -> object_drop=1 for exactly 10 cycles, then all outputs 0.
REQ-034 Bounce: fault_sense toggles every 2 cycles for 40 cycles -> fault_detect stays 0; node_sense high for 3 cycles then low -> no node_flag.
REQ-035 Node: node_sense held high -> exactly one node_flag pulse 4 cycles after synchronisation; no second pulse while held.
REQ-036 Priority: run_done and drop_done in the same cycle while in HOLDING -> run_complete=1, object_drop never asserts, and run_complete remains 1 for 100 further cycles.
REQ-037 Reset mid-hold: rst_n low at hold cycle 5 -> all outputs 0 asynchronously; after release with unit_sel=00 the outputs stay 0.
REQ-038 Zone lock: unit_sel changes 01 to 11 while in FAULT -> EU_fault_flag stays 1 and RU_fault_flag stays 0 until the return to IDLE.

Source files
------------

// File: rtl/led_event_encoder.sv
// LED event encoder: debounces the fault and node sensors, tracks the pick/drop sequence for one zone, and drives status LEDs.
// Latency: every output is registered and changes 1 cycle after the event that qualifies it; sensors add 2 sync cycles plus DEB_CYCLES.
// Backpressure: none; the arm and planner pulses are consumed in the cycle they arrive, and pulses with no effect in the current state are dropped.
module led_event_encoder #(
  parameter int DEB_CYCLES  = 3125,
  parameter int HOLD_CYCLES = 3125000
) (
  input  logic       clk_3125KHz,
  input  logic       rst_n,
  input  logic [1:0] unit_sel,
  input  logic       fault_sense,
  input  logic       node_sense,
  input  logic       pick_done,
  input  logic       drop_done,
  input  logic       run_done,
  output logic       fault_detect,
  output logic       block_picked,
  output logic       node_flag,
  output logic       object_drop,
  output logic       run_complete,
  output logic       EU_fault_flag,
  output logic       CU_fault_flag,
  output logic       RU_fault_flag
);

  // The debounce counter must reach DEB_CYCLES itself, so it gets one extra value
  localparam int DW = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'((DEB_CYCLES > 0) ? DEB_CYCLES - 1 : 0);
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    FAULT   = 3'd2,
    HOLDING = 3'd3,
    DROPPED = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    zone, zone_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;

  logic          fault_s1, fault_s2, node_s1, node_s2;
  logic          fault_deb, node_deb;
  logic [DW-1:0] fault_cnt, node_cnt;
  logic          node_rise;
  logic          zone_on;

  // Two-flop synchronisers for the raw, asynchronous sensor levels
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      fault_s1 <= 1'b0;
      fault_s2 <= 1'b0;
      node_s1  <= 1'b0;
      node_s2  <= 1'b0;
    end else begin
      fault_s1 <= fault_sense;
      fault_s2 <= fault_s1;
      node_s1  <= node_sense;
      node_s2  <= node_s1;
    end
  end

  // Fault debounce: the level flips on the DEB_CYCLES-th consecutive disagreeing cycle
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      fault_deb <= 1'b0;
      fault_cnt <= '0;
    end else if (fault_s2 == fault_deb) begin
      fault_cnt <= '0;
    end else if (fault_cnt >= DEB_LAST) begin
      fault_deb <= fault_s2;
      fault_cnt <= '0;
    end else if (fault_cnt != DEB_MAX) begin
      fault_cnt <= fault_cnt + DW'(1);
    end
  end

  // Node flips high in exactly the cycle the debounced level is about to rise
  assign node_rise = node_s2 && !node_deb && (node_cnt >= DEB_LAST);

  // Node debounce, with the flag registered alongside the debounced level
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      node_deb  <= 1'b0;
      node_cnt  <= '0;
      node_flag <= 1'b0;
    end else begin
      node_flag <= node_rise && (state != DONE) && !run_done;
      if (node_s2 == node_deb) begin
        node_cnt <= '0;
      end else if (node_cnt >= DEB_LAST) begin
        node_deb <= node_s2;
        node_cnt <= '0;
      end else if (node_cnt != DEB_MAX) begin
        node_cnt <= node_cnt + DW'(1);
      end
    end
  end

  // Next-state logic; run_done overrides everything, otherwise one listed transition per state
  always_comb begin
    state_nxt = state;
    zone_nxt  = zone;
    hold_nxt  = hold_cnt;
    if (run_done) begin
      state_nxt = DONE;
      zone_nxt  = 2'b00;
      hold_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (unit_sel != 2'b00) begin
            state_nxt = ARMED;
            zone_nxt  = unit_sel;
          end
        end
        ARMED: begin
          if (fault_deb) state_nxt = FAULT;
        end
        FAULT: begin
          if (pick_done) state_nxt = HOLDING;
        end
        HOLDING: begin
          if (drop_done) begin
            state_nxt = DROPPED;
            hold_nxt  = HOLD_LAST;
          end
        end
        DROPPED: begin
          if (hold_cnt == '0) begin
            state_nxt = IDLE;
            zone_nxt  = 2'b00;
          end else begin
            hold_nxt = hold_cnt - HW'(1);
          end
        end
        DONE: begin
          state_nxt = DONE;
        end
        default: begin
          state_nxt = IDLE;
          zone_nxt  = 2'b00;
          hold_nxt  = '0;
        end
      endcase
    end
  end

  // Zone LEDs light in every active state between arming and the return to IDLE
  assign zone_on = (state_nxt == ARMED) || (state_nxt == FAULT) ||
                   (state_nxt == HOLDING) || (state_nxt == DROPPED);

  // State register with outputs decoded from the next state so they land on the same edge
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      zone          <= 2'b00;
      hold_cnt      <= '0;
      fault_detect  <= 1'b0;
      block_picked  <= 1'b0;
      object_drop   <= 1'b0;
      run_complete  <= 1'b0;
      EU_fault_flag <= 1'b0;
      CU_fault_flag <= 1'b0;
      RU_fault_flag <= 1'b0;
    end else begin
      state         <= state_nxt;
      zone          <= zone_nxt;
      hold_cnt      <= hold_nxt;
      fault_detect  <= (state_nxt == FAULT);
      block_picked  <= (state_nxt == HOLDING);
      object_drop   <= (state_nxt == DROPPED);
      run_complete  <= (state_nxt == DONE);
      EU_fault_flag <= zone_on && (zone_nxt == 2'b01);
      CU_fault_flag <= zone_on && (zone_nxt == 2'b10);
      RU_fault_flag <= zone_on && (zone_nxt == 2'b11);
    end
  end

endmodule

// File: tb/tb_led_event_encoder.sv
// Directed bench for led_event_encoder with short debounce and hold windows.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
// Output vector order: fault_detect, block_picked, node_flag, object_drop, run_complete, EU, CU, RU.
module tb_led_event_encoder;

  logic       clk_3125KHz = 1'b0;
  logic       rst_n       = 1'b0;
  logic [1:0] unit_sel    = 2'b00;
  logic       fault_sense = 1'b0;
  logic       node_sense  = 1'b0;
  logic       pick_done   = 1'b0;
  logic       drop_done   = 1'b0;
  logic       run_done    = 1'b0;
  logic fault_detect, block_picked, node_flag, object_drop, run_complete;
  logic EU_fault_flag, CU_fault_flag, RU_fault_flag;
  logic [7:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  led_event_encoder #(.DEB_CYCLES(4), .HOLD_CYCLES(10)) dut (
    .clk_3125KHz  (clk_3125KHz),
    .rst_n        (rst_n),
    .unit_sel     (unit_sel),
    .fault_sense  (fault_sense),
    .node_sense   (node_sense),
    .pick_done    (pick_done),
    .drop_done    (drop_done),
    .run_done     (run_done),
    .fault_detect (fault_detect),
    .block_picked (block_picked),
    .node_flag    (node_flag),
    .object_drop  (object_drop),
    .run_complete (run_complete),
    .EU_fault_flag(EU_fault_flag),
    .CU_fault_flag(CU_fault_flag),
    .RU_fault_flag(RU_fault_flag)
  );

  assign outs = {fault_detect, block_picked, node_flag, object_drop, run_complete,
                 EU_fault_flag, CU_fault_flag, RU_fault_flag};

  always #5 clk_3125KHz = ~clk_3125KHz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_3125KHz);
    #1;
  endtask

  // Six stable high cycles debounce the fault; one more edge enters FAULT
  task automatic raise_fault();
    fault_sense = 1'b1;
    repeat (6) tick();
    fault_sense = 1'b0;
    tick();
  endtask

  task automatic pulse_pick();
    pick_done = 1'b1;
    tick();
    pick_done = 1'b0;
  endtask

  task automatic pulse_drop();
    drop_done = 1'b1;
    tick();
    drop_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int bad;
    int first;

    // Reset state
    repeat (3) tick();
    check("reset_outs", outs, 8'h00);
    rst_n = 1'b1;
    tick();
    check("idle_outs", outs, 8'h00);

    // Full sequence in zone CU
    unit_sel = 2'b10;
    tick();
    unit_sel = 2'b00;
    check("armed_cu", outs, 8'b0000_0010);
    fault_sense = 1'b1;
    repeat (6) tick();
    fault_sense = 1'b0;
    check("fault_latency", outs, 8'b0000_0010);
    tick();
    check("fault_cu", outs, 8'b1000_0010);
    pulse_pick();
    check("holding_cu", outs, 8'b0100_0010);
    pulse_drop();
    check("dropped_cu", outs, 8'b0001_0010);
    cnt = 0;
    for (int i = 0; i < 50 && object_drop; i++) begin
      cnt++;
      tick();
    end
    check("drop_len", cnt, 10);
    check("after_drop", outs, 8'h00);

    // Bounce rejection while armed in EU
    unit_sel = 2'b01;
    tick();
    unit_sel = 2'b00;
    check("armed_eu", outs, 8'b0000_0100);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      fault_sense = ((i / 2) % 2) == 1;
      tick();
      if (fault_detect) bad++;
    end
    fault_sense = 1'b0;
    repeat (8) begin
      tick();
      if (fault_detect) bad++;
    end
    check("bounce_fault", bad, 0);
    check("bounce_armed", outs, 8'b0000_0100);
    cnt = 0;
    node_sense = 1'b1;
    repeat (3) begin
      tick();
      if (node_flag) cnt++;
    end
    node_sense = 1'b0;
    repeat (20) begin
      tick();
      if (node_flag) cnt++;
    end
    check("bounce_node", cnt, 0);

    // Node pulse timing: two sync edges plus four debounce edges
    node_sense = 1'b1;
    cnt = 0;
    first = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (node_flag) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    check("node_latency", first, 5);
    check("node_count", cnt, 1);
    node_sense = 1'b0;
    cnt = 0;
    repeat (12) begin
      tick();
      if (node_flag) cnt++;
    end
    check("node_fall", cnt, 0);

    // Zone lock: unit_sel moves to RU while FAULT in EU
    raise_fault();
    check("fault_eu", outs, 8'b1000_0100);
    unit_sel = 2'b11;
    tick();
    check("zone_lock", outs, 8'b1000_0100);
    pulse_pick();
    pulse_drop();
    bad = 0;
    for (int i = 0; i < 50 && object_drop; i++) begin
      if (!EU_fault_flag || RU_fault_flag) bad++;
      tick();
    end
    check("zone_lock_hold", bad, 0);
    check("zone_idle", outs, 8'h00);
    tick();
    unit_sel = 2'b00;
    check("zone_relatch", outs, 8'b0000_0001);

    // Reset at hold cycle 5
    raise_fault();
    pulse_pick();
    pulse_drop();
    repeat (5) tick();
    check("pre_reset_drop", outs, 8'b0001_0001);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", outs, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
    bad = 0;
    repeat (15) begin
      tick();
      if (outs != 8'h00) bad++;
    end
    check("reset_quiet", bad, 0);

    // Priority: run_done with drop_done in HOLDING
    unit_sel = 2'b10;
    tick();
    unit_sel = 2'b00;
    raise_fault();
    pulse_pick();
    check("holding_prio", outs, 8'b0100_0010);
    run_done = 1'b1;
    drop_done = 1'b1;
    tick();
    run_done = 1'b0;
    drop_done = 1'b0;
    check("prio_done", outs, 8'b0000_1000);
    node_sense = 1'b1;
    unit_sel = 2'b01;
    bad = 0;
    repeat (100) begin
      tick();
      if (outs != 8'b0000_1000) bad++;
    end
    node_sense = 1'b0;
    unit_sel = 2'b00;
    check("done_sticky", bad, 0);

    // Reset out of DONE
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_done", outs, 8'h00);
    tick();
    rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      tick();
      if (outs != 8'h00) bad++;
    end
    check("reset_done_quiet", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
